// File: rtl/ucore_pkg.sv
// ucore_pkg: shared definitions for the ucore accumulator core.
//   - opcode encodings (IR[31:28])
//   - sequencer state enumeration
//   - fixed AXI attribute values used on the master port
package ucore_pkg;

    // Opcodes; every encoding not listed here executes as a NOP.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h1;
    localparam logic [3:0] OP_ST  = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JZ  = 4'h5;

    typedef enum logic [2:0] {
        ST_FETCH_AR = 3'd0,
        ST_FETCH_R  = 3'd1,
        ST_EXEC     = 3'd2,
        ST_DATA_AR  = 3'd3,
        ST_DATA_R   = 3'd4,
        ST_WR       = 3'd5,
        ST_WR_B     = 3'd6
    } state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [2:0] PROT_INSN  = 3'b100;
    localparam logic [2:0] PROT_DATA  = 3'b000;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/ucore_axi_rd_port.sv
// ucore_axi_rd_port: single-beat AXI read handshake shared by instruction
// fetch and data loads.
//   start_i   : one-cycle request; address/prot captured, arvalid raised next cycle
//   araddr_o / arprot_o / arvalid_o / arready_i : AR channel
//   ar_fire_o : AR handshake happens this cycle
//   rvalid_i / rready_o : R channel handshake (rdata/rresp consumed by the owner)
//   done_o    : R beat accepted this cycle
module ucore_axi_rd_port #(
    parameter int ADDR_W = 28
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        prot_i,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [2:0]        arprot_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    output logic              ar_fire_o,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic              done_o
);
    import ucore_pkg::*;

    logic [ADDR_W-1:0] araddr_q;
    logic [2:0]        arprot_q;
    logic              arvalid_q;
    logic              rready_q;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            araddr_q  <= '0;
            arprot_q  <= PROT_DATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else if (start_i) begin
            // A new request may coincide with the previous R beat completing.
            araddr_q  <= addr_i;
            arprot_q  <= prot_i;
            arvalid_q <= 1'b1;
            rready_q  <= 1'b0;
        end else begin
            if (arvalid_q && arready_i) begin
                arvalid_q <= 1'b0;
                rready_q  <= 1'b1;
            end
            if (rready_q && rvalid_i) begin
                rready_q <= 1'b0;
            end
        end
    end

    assign araddr_o  = araddr_q;
    assign arprot_o  = arprot_q;
    assign arvalid_o = arvalid_q;
    assign rready_o  = rready_q;
    assign ar_fire_o = arvalid_q & arready_i;
    assign done_o    = rready_q & rvalid_i;

endmodule

// File: rtl/ucore_main.sv
// ucore_main: microcoded accumulator core with a single AXI4 master port.
//   clk, aresetn   : clock and synchronous active-low reset
//   m_axi_ar* / r* : instruction fetch and data loads (via ucore_axi_rd_port)
//   m_axi_aw* / w* / b* : single-beat data stores
// Architectural state is PC, ACC and IR; one AXI transaction in flight at a time.
module ucore_main #(
    parameter int                ADDR_W   = 28,
    parameter int                DATA_W   = 32,
    parameter int                ID_W     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              aresetn,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [1:0]        m_axi_arburst,
    output logic [3:0]        m_axi_arcache,
    output logic [ID_W-1:0]   m_axi_arid,
    output logic [7:0]        m_axi_arlen,
    output logic              m_axi_arlock,
    output logic [2:0]        m_axi_arprot,
    output logic [3:0]        m_axi_arqos,
    output logic [2:0]        m_axi_arsize,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [ID_W-1:0]   m_axi_rid,
    input  logic              m_axi_rlast,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [1:0]        m_axi_awburst,
    output logic [3:0]        m_axi_awcache,
    output logic [ID_W-1:0]   m_axi_awid,
    output logic [7:0]        m_axi_awlen,
    output logic              m_axi_awlock,
    output logic [2:0]        m_axi_awprot,
    output logic [3:0]        m_axi_awqos,
    output logic [2:0]        m_axi_awsize,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [ID_W-1:0]   m_axi_bid,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready
);
    import ucore_pkg::*;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] ir_q;
    logic              kick_q;      // launches the first fetch after reset
    logic [ADDR_W-1:0] awaddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              bready_q;

    logic [3:0]        op;
    logic [ADDR_W-1:0] opnd;
    logic [ADDR_W-1:0] pc_d;
    logic              rd_start;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        rd_prot;
    logic              ar_fire;
    logic              rd_done;
    logic              aw_done;
    logic              w_done;
    logic              unused_inputs;

    assign op   = ir_q[DATA_W-1 -: 4];
    assign opnd = {ir_q[ADDR_W-1:2], 2'b00};

    // PC after EXEC: jump target or sequential, wrapping at the address width.
    assign pc_d = ((op == OP_JMP) || (op == OP_JZ && acc_q == '0)) ? opnd
                                                                   : pc_q + ADDR_W'(4);

    // A write channel is finished once its valid has dropped or is accepted now.
    assign aw_done = !awvalid_q || m_axi_awready;
    assign w_done  = !wvalid_q  || m_axi_wready;

    // Read requests are issued on the same cycle the sequencer enters an AR
    // state, so arvalid is high for the whole time the state is occupied.
    always_comb begin
        rd_start = 1'b0;
        rd_addr  = pc_q;
        rd_prot  = PROT_INSN;
        case (state_q)
            ST_FETCH_AR: rd_start = kick_q;
            ST_EXEC: begin
                if (op == OP_LD || op == OP_ADD) begin
                    rd_start = 1'b1;
                    rd_addr  = opnd;
                    rd_prot  = PROT_DATA;
                end else if (op != OP_ST) begin
                    rd_start = 1'b1;
                    rd_addr  = pc_d;
                end
            end
            ST_DATA_R:   rd_start = rd_done;
            ST_WR_B:     rd_start = m_axi_bvalid;
            default:     rd_start = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q   <= ST_FETCH_AR;
            pc_q      <= RESET_PC;
            acc_q     <= '0;
            ir_q      <= '0;
            kick_q    <= 1'b1;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            kick_q <= 1'b0;
            case (state_q)
                ST_FETCH_AR: if (ar_fire) state_q <= ST_FETCH_R;
                ST_FETCH_R: begin
                    if (rd_done) begin
                        // An errored fetch executes as a NOP.
                        ir_q    <= (m_axi_rresp == RESP_OKAY) ? m_axi_rdata : '0;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    pc_q <= pc_d;
                    case (op)
                        OP_LD, OP_ADD: state_q <= ST_DATA_AR;
                        OP_ST: begin
                            awaddr_q  <= opnd;
                            wdata_q   <= acc_q;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WR;
                        end
                        default: state_q <= ST_FETCH_AR;
                    endcase
                end
                ST_DATA_AR: if (ar_fire) state_q <= ST_DATA_R;
                ST_DATA_R: begin
                    if (rd_done) begin
                        if (m_axi_rresp == RESP_OKAY) begin
                            acc_q <= (op == OP_LD) ? m_axi_rdata : acc_q + m_axi_rdata;
                        end
                        state_q <= ST_FETCH_AR;
                    end
                end
                ST_WR: begin
                    if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
                    if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        state_q  <= ST_FETCH_AR;
                    end
                end
                default: state_q <= ST_FETCH_AR;
            endcase
        end
    end

    ucore_axi_rd_port #(
        .ADDR_W (ADDR_W)
    ) u_rd_port (
        .clk       (clk),
        .aresetn   (aresetn),
        .start_i   (rd_start),
        .addr_i    (rd_addr),
        .prot_i    (rd_prot),
        .araddr_o  (m_axi_araddr),
        .arprot_o  (m_axi_arprot),
        .arvalid_o (m_axi_arvalid),
        .arready_i (m_axi_arready),
        .ar_fire_o (ar_fire),
        .rvalid_i  (m_axi_rvalid),
        .rready_o  (m_axi_rready),
        .done_o    (rd_done)
    );

    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arcache = 4'h0;
    assign m_axi_arid    = '0;
    assign m_axi_arlen   = 8'h00;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arqos   = 4'h0;
    assign m_axi_arsize  = SIZE_4B;

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awcache = 4'h0;
    assign m_axi_awid    = '0;
    assign m_axi_awlen   = 8'h00;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awprot  = PROT_DATA;
    assign m_axi_awqos   = 4'h0;
    assign m_axi_awsize  = SIZE_4B;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;

    // IDs, rlast, bresp and the operand's low address bits carry no meaning here.
    assign unused_inputs = ^{m_axi_rid, m_axi_rlast, m_axi_bid, m_axi_bresp, ir_q[1:0]};

endmodule

// File: tb/tb_ucore_main.sv
// tb_ucore_main: directed bench for ucore_main with a small behavioural AXI
// slave (memory, per-channel stall knobs, error injection) that logs every
// handshake. Each test task drives a program and checks the logs inline.
module tb_ucore_main;
    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [27:0] m_axi_araddr;
    logic [1:0]  m_axi_arburst;
    logic [3:0]  m_axi_arcache;
    logic [3:0]  m_axi_arid;
    logic [7:0]  m_axi_arlen;
    logic        m_axi_arlock;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arqos;
    logic [2:0]  m_axi_arsize;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [3:0]  m_axi_rid = '0;
    logic        m_axi_rlast = 1'b1;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;
    logic [27:0] m_axi_awaddr;
    logic [1:0]  m_axi_awburst;
    logic [3:0]  m_axi_awcache;
    logic [3:0]  m_axi_awid;
    logic [7:0]  m_axi_awlen;
    logic        m_axi_awlock;
    logic [2:0]  m_axi_awprot;
    logic [3:0]  m_axi_awqos;
    logic [2:0]  m_axi_awsize;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [3:0]  m_axi_bid = '0;
    logic [1:0]  m_axi_bresp = '0;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Slave memory, knobs and logs
    logic [31:0] mem [logic [27:0]];
    int          ar_stall, aw_stall, w_stall, b_delay;
    logic        ar_block, err_en;
    logic [27:0] err_addr;
    logic [1:0]  err_resp;
    logic [27:0] ar_addr_log[$];
    logic [2:0]  ar_prot_log[$];
    int          ar_cyc_log[$];
    logic [27:0] aw_addr_log[$];
    logic [31:0] w_data_log[$];
    logic [3:0]  w_strb_log[$];
    logic        w_last_log[$];
    logic        rd_pend, b_pend, aw_got, w_got, ar_wait;
    logic [27:0] rd_addr, ar_wait_addr;
    int          b_cnt;

    always #5 clk = ~clk;

    ucore_main dut (
        .clk(clk), .aresetn(aresetn),
        .m_axi_araddr(m_axi_araddr), .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache),
        .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen), .m_axi_arlock(m_axi_arlock),
        .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos), .m_axi_arsize(m_axi_arsize),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rid(m_axi_rid), .m_axi_rlast(m_axi_rlast),
        .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache),
        .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen), .m_axi_awlock(m_axi_awlock),
        .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awsize(m_axi_awsize),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    // Slave: decides at each falling edge what handshakes occur at the next
    // rising edge (DUT outputs are stable between the two).
    always @(negedge clk) begin
        cyc++;
        if (!aresetn) begin
            m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rresp = 0;
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            rd_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; ar_wait = 0;
        end else begin
            if (ar_wait) begin
                checks++;
                if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== ar_wait_addr) begin
                    errors++;
                    $display("FAIL ar_hold: arvalid=%b araddr=%h, required arvalid=1 araddr=%h",
                             m_axi_arvalid, m_axi_araddr, ar_wait_addr);
                end
            end
            // R channel: beat presented the cycle after the AR handshake
            if (rd_pend) begin
                m_axi_rvalid = 1;
                m_axi_rdata  = mem.exists(rd_addr) ? mem[rd_addr] : 32'h0;
                m_axi_rresp  = (err_en && rd_addr == err_addr) ? err_resp : 2'b00;
                if (m_axi_rready) begin
                    $display("R    data=%h resp=%b", m_axi_rdata, m_axi_rresp);
                    rd_pend = 0;
                end
            end else begin
                m_axi_rvalid = 0;
                m_axi_rresp  = 0;
            end
            // AR channel
            m_axi_arready = !ar_block && ar_stall == 0;
            if (m_axi_arvalid && !m_axi_arready && ar_stall > 0) ar_stall--;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_addr_log.push_back(m_axi_araddr);
                ar_prot_log.push_back(m_axi_arprot);
                ar_cyc_log.push_back(cyc);
                $display("AR   addr=%h prot=%b cyc=%0d", m_axi_araddr, m_axi_arprot, cyc);
                rd_pend = 1;
                rd_addr = m_axi_araddr;
                ar_wait = 0;
            end else begin
                ar_wait      = m_axi_arvalid;
                ar_wait_addr = m_axi_araddr;
            end
            // W must have dropped once its own handshake finished
            if (w_got && !aw_got) begin
                checks++;
                if (m_axi_wvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL wvalid_drop: wvalid=%b, required 0", m_axi_wvalid);
                end
            end
            m_axi_awready = aw_stall == 0;
            if (m_axi_awvalid && !m_axi_awready) aw_stall--;
            m_axi_wready = w_stall == 0;
            if (m_axi_wvalid && !m_axi_wready) w_stall--;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_addr_log.push_back(m_axi_awaddr);
                $display("AW   addr=%h cyc=%0d", m_axi_awaddr, cyc);
                aw_got = 1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_data_log.push_back(m_axi_wdata);
                w_strb_log.push_back(m_axi_wstrb);
                w_last_log.push_back(m_axi_wlast);
                $display("W    data=%h strb=%h cyc=%0d", m_axi_wdata, m_axi_wstrb, cyc);
                w_got = 1;
            end
            // B channel
            if (b_pend) begin
                if (b_cnt > 0) begin
                    b_cnt--;
                    m_axi_bvalid = 0;
                end else begin
                    m_axi_bvalid = 1;
                    if (m_axi_bready) begin
                        $display("B    cyc=%0d", cyc);
                        b_pend = 0;
                    end
                end
            end else begin
                m_axi_bvalid = 0;
            end
            if (aw_got && w_got) begin
                b_pend = 1; b_cnt = b_delay; aw_got = 0; w_got = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_hold();
        aresetn = 0;
        ar_stall = 0; aw_stall = 0; w_stall = 0; b_delay = 0;
        ar_block = 0; err_en = 0; err_addr = '0; err_resp = '0;
        mem.delete();
        repeat (2) tick();
        ar_addr_log.delete(); ar_prot_log.delete(); ar_cyc_log.delete();
        aw_addr_log.delete(); w_data_log.delete(); w_strb_log.delete(); w_last_log.delete();
    endtask

    task automatic wait_reads(input int n);
        int t = 0;
        aresetn = 1;
        while (ar_addr_log.size() < n && t < 400) begin tick(); t++; end
        checks++;
        if (ar_addr_log.size() < n) begin
            errors++;
            $display("FAIL read_timeout: reads=%0d, required %0d", ar_addr_log.size(), n);
        end
    endtask

    task automatic test_reset();
        reset_hold();
        checks += 5;
        if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid: got %b, required 0", m_axi_arvalid); end
        if (m_axi_rready  !== 1'b0) begin errors++; $display("FAIL rst_rready: got %b, required 0", m_axi_rready); end
        if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0) begin
            errors++; $display("FAIL rst_wvalids: aw=%b w=%b, required 0 0", m_axi_awvalid, m_axi_wvalid);
        end
        if (m_axi_bready  !== 1'b0) begin errors++; $display("FAIL rst_bready: got %b, required 0", m_axi_bready); end
        if (m_axi_araddr !== 28'h0 || m_axi_awaddr !== 28'h0 || m_axi_wdata !== 32'h0) begin
            errors++; $display("FAIL rst_addr: araddr=%h awaddr=%h wdata=%h, required 0", m_axi_araddr, m_axi_awaddr, m_axi_wdata);
        end
    endtask

    task automatic test_nop_fetch();
        logic [27:0] ea [3];
        ea = '{28'h0, 28'h4, 28'h8};
        reset_hold();
        ar_stall = 2;
        wait_reads(3);
        for (int i = 0; i < 3 && i < ar_addr_log.size(); i++) begin
            checks++;
            if (ar_addr_log[i] !== ea[i] || ar_prot_log[i] !== 3'b100) begin
                errors++;
                $display("FAIL nop_fetch[%0d]: addr=%h prot=%b, required addr=%h prot=100",
                         i, ar_addr_log[i], ar_prot_log[i], ea[i]);
            end
        end
        if (ar_cyc_log.size() >= 3) begin
            checks++;
            if (ar_cyc_log[2] - ar_cyc_log[1] !== 3) begin
                errors++; $display("FAIL nop_latency: %0d cycles, required 3", ar_cyc_log[2] - ar_cyc_log[1]);
            end
        end
    endtask

    task automatic test_ld_add();
        logic [27:0] ea [6];
        logic [2:0]  ep [6];
        ea = '{28'h0, 28'h40, 28'h4, 28'h40, 28'h8, 28'hC};
        ep = '{3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 3'b100};
        reset_hold();
        mem[28'h0] = 32'h10000040; mem[28'h40] = 32'h00000007;
        mem[28'h4] = 32'h30000040; mem[28'h8] = 32'h20000080;
        wait_reads(6);
        for (int i = 0; i < 6 && i < ar_addr_log.size(); i++) begin
            checks++;
            if (ar_addr_log[i] !== ea[i] || ar_prot_log[i] !== ep[i]) begin
                errors++;
                $display("FAIL ld_add_rd[%0d]: addr=%h prot=%b, required addr=%h prot=%b",
                         i, ar_addr_log[i], ar_prot_log[i], ea[i], ep[i]);
            end
        end
        checks++;
        if (w_data_log.size() != 1 || w_data_log[0] !== 32'h0000000E) begin
            errors++; $display("FAIL ld_add_acc: writes=%0d data=%h, required 1 write of 0000000e",
                               w_data_log.size(), (w_data_log.size() > 0) ? w_data_log[0] : 32'hx);
        end
        if (ar_cyc_log.size() >= 6) begin
            checks += 2;
            if (ar_cyc_log[2] - ar_cyc_log[0] !== 5) begin
                errors++; $display("FAIL ld_latency: %0d cycles, required 5", ar_cyc_log[2] - ar_cyc_log[0]);
            end
            if (ar_cyc_log[5] - ar_cyc_log[4] !== 5) begin
                errors++; $display("FAIL st_latency: %0d cycles, required 5", ar_cyc_log[5] - ar_cyc_log[4]);
            end
        end
    endtask

    task automatic test_store();
        reset_hold();
        mem[28'h0] = 32'h20000083;
        aw_stall = 3; w_stall = 0; b_delay = 2;
        wait_reads(2);
        checks += 3;
        if (aw_addr_log.size() != 1 || aw_addr_log[0] !== 28'h80) begin
            errors++; $display("FAIL st_awaddr: count=%0d addr=%h, required 1 at 0000080",
                               aw_addr_log.size(), (aw_addr_log.size() > 0) ? aw_addr_log[0] : 28'hx);
        end
        if (w_data_log.size() != 1 || w_data_log[0] !== 32'h0 || w_strb_log[0] !== 4'hF || w_last_log[0] !== 1'b1) begin
            errors++; $display("FAIL st_wdata: count=%0d, required 1 beat data=0 strb=f last=1", w_data_log.size());
        end
        if (ar_addr_log.size() >= 2 && ar_addr_log[1] !== 28'h4) begin
            errors++; $display("FAIL st_next_fetch: addr=%h, required 0000004", ar_addr_log[1]);
        end
    endtask

    task automatic test_branch();
        logic [27:0] ea [4];
        // JZ with ACC == 0
        reset_hold();
        mem[28'h0] = 32'h50000100;
        wait_reads(2);
        checks++;
        if (ar_addr_log[1] !== 28'h100) begin errors++; $display("FAIL jz_taken: addr=%h, required 0000100", ar_addr_log[1]); end
        // JZ with ACC == 7
        reset_hold();
        mem[28'h0] = 32'h10000040; mem[28'h40] = 32'h7; mem[28'h4] = 32'h50000100;
        ea = '{28'h0, 28'h40, 28'h4, 28'h8};
        wait_reads(4);
        for (int i = 0; i < 4 && i < ar_addr_log.size(); i++) begin
            checks++;
            if (ar_addr_log[i] !== ea[i]) begin
                errors++; $display("FAIL jz_not_taken[%0d]: addr=%h, required %h", i, ar_addr_log[i], ea[i]);
            end
        end
        // JMP at the top of the address space
        reset_hold();
        mem[28'h0] = 32'h4FFFFFFC; mem[28'hFFFFFFC] = 32'h40000200;
        wait_reads(3);
        checks += 2;
        if (ar_addr_log[1] !== 28'hFFFFFFC) begin errors++; $display("FAIL jmp_top: addr=%h, required ffffffc", ar_addr_log[1]); end
        if (ar_addr_log[2] !== 28'h200) begin errors++; $display("FAIL jmp_from_top: addr=%h, required 0000200", ar_addr_log[2]); end
        // NOP at the top wraps the PC
        reset_hold();
        mem[28'h0] = 32'h4FFFFFFC;
        wait_reads(3);
        checks++;
        if (ar_addr_log[2] !== 28'h0) begin errors++; $display("FAIL pc_wrap: addr=%h, required 0000000", ar_addr_log[2]); end
    endtask

    task automatic test_resp_err();
        // Errored fetch of a JMP executes as NOP
        reset_hold();
        mem[28'h0] = 32'h40000100;
        err_en = 1; err_addr = 28'h0; err_resp = 2'b10;
        wait_reads(2);
        checks++;
        if (ar_addr_log[1] !== 28'h4) begin errors++; $display("FAIL fetch_err: addr=%h, required 0000004", ar_addr_log[1]); end
        // Errored LD leaves ACC (7) unchanged
        reset_hold();
        mem[28'h0] = 32'h10000040; mem[28'h40] = 32'h7;
        mem[28'h4] = 32'h10000050; mem[28'h50] = 32'h9;
        mem[28'h8] = 32'h20000080;
        err_en = 1; err_addr = 28'h50; err_resp = 2'b11;
        wait_reads(6);
        checks += 2;
        if (ar_addr_log[3] !== 28'h50 || ar_prot_log[3] !== 3'b000) begin
            errors++; $display("FAIL ld_err_rd: addr=%h prot=%b, required 0000050 000", ar_addr_log[3], ar_prot_log[3]);
        end
        if (w_data_log.size() != 1 || w_data_log[0] !== 32'h7) begin
            errors++; $display("FAIL ld_err_acc: writes=%0d data=%h, required 1 write of 00000007",
                               w_data_log.size(), (w_data_log.size() > 0) ? w_data_log[0] : 32'hx);
        end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        reset_hold();
        mem[28'h0] = 32'h40000100;
        wait_reads(1);
        ar_block = 1;
        while (!(m_axi_arvalid === 1'b1 && m_axi_araddr === 28'h100) && t < 50) begin tick(); t++; end
        checks++;
        if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 28'h100) begin
            errors++; $display("FAIL mid_stall: arvalid=%b araddr=%h, required 1 0000100", m_axi_arvalid, m_axi_araddr);
        end
        aresetn = 0;
        tick();
        checks++;
        if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_arvalid: got %b, required 0", m_axi_arvalid); end
        ar_addr_log.delete(); ar_prot_log.delete(); ar_cyc_log.delete();
        ar_block = 0;
        wait_reads(1);
        checks++;
        if (ar_addr_log.size() > 0 && (ar_addr_log[0] !== 28'h0 || ar_prot_log[0] !== 3'b100)) begin
            errors++; $display("FAIL mid_restart: addr=%h prot=%b, required 0000000 100", ar_addr_log[0], ar_prot_log[0]);
        end
    endtask

    initial begin
        test_reset();
        test_nop_fetch();
        test_ld_add();
        test_store();
        test_branch();
        test_resp_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
